aes_dec_iter: RTL and testbench

- Iterative AES-128 inverse cipher. Turns a 128-bit ciphertext back into plaintext, one round per clock.
- Decryption counterpart of the unrolled combinational AES-128 encryptor. Consumes the same 11 expanded round keys that the garbling flow supplies through `g_input`.
- Start/busy/done handshake. The result is held on `o` until the next operation completes.
- Round functions are InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns, all instantiated once inside the block.

---
 rtl/aes_dec_iter.sv | 164 ++++++++++++++++
 tb/tb_aes_dec_iter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_iter.sv
// rtl/aes_dec_iter.sv - iterative AES-128 inverse cipher, one round per clock
module aes_dec_iter #(
  parameter int LATCH_KEYS = 1,
  parameter int NR         = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1407:0] g_input,
  input  logic [127:0]  e_input,
  output logic          busy,
  output logic          done,
  output logic [127:0]  o
);

  // Inverse S-box ROM, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [127:0]  blk_q, blk_d;
  logic [127:0]  o_q, o_d;
  logic [3:0]    rnd_q, rnd_d;
  logic          done_q, done_d;
  logic          accept;
  logic [1407:0] keys;
  logic [127:0]  rk, isr, isb, ark, imc;

  function automatic logic [7:0] inv_sub(input logic [7:0] b);
    return INV_SBOX[(11'd2047 - {b, 3'b000}) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by the fixed InvMixColumns coefficients 09/0b/0d/0e.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] m2, m4, m8;
    m2 = xt(a);
    m4 = xt(m2);
    m8 = xt(m4);
    case (k)
      4'h9:    return m8 ^ a;
      4'hb:    return m8 ^ m2 ^ a;
      4'hd:    return m8 ^ m4 ^ a;
      default: return m8 ^ m4 ^ m2;
    endcase
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
  endfunction

  // Row r rotates right by r columns; byte index is row + 4*column.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] t;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    return t;
  endfunction

  generate
    if (LATCH_KEYS != 0) begin : g_latch
      logic [1407:0] keys_q;
      // Capture the round keys together with the ciphertext
      always_ff @(posedge clk) begin
        if (!rst) keys_q <= '0;
        else if (accept) keys_q <= g_input;
      end
      assign keys = keys_q;
    end else begin : g_direct
      assign keys = g_input;
    end
  endgenerate

  assign accept = (fsm_q == IDLE) && start;

  // rnd_q already holds 0 during FINAL, so one index serves both paths.
  assign rk = keys[{rnd_q, 7'b0000000} +: 128];

  // Single round datapath shared by the middle rounds and the final round
  always_comb begin
    isr = inv_shift_rows(blk_q);
    isb = '0;
    for (int k = 0; k < 16; k++) begin
      isb[127 - 8*k -: 8] = inv_sub(isr[127 - 8*k -: 8]);
    end
    ark = isb ^ rk;
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      imc[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
    end
  end

  // Next-state and datapath register selection
  always_comb begin
    fsm_d  = fsm_q;
    blk_d  = blk_q;
    rnd_d  = rnd_q;
    o_d    = o_q;
    done_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          blk_d = e_input ^ g_input[128*NR +: 128];
          rnd_d = 4'(NR - 1);
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        blk_d = imc;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        o_d    = ark;
        done_d = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q  <= IDLE;
      blk_q  <= '0;
      rnd_q  <= '0;
      o_q    <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      blk_q  <= blk_d;
      rnd_q  <= rnd_d;
      o_q    <= o_d;
      done_q <= done_d;
    end
  end

  assign busy = (fsm_q != IDLE);
  assign done = done_q;
  assign o    = o_q;

endmodule

// File: tb/tb_aes_dec_iter.sv
// tb/tb_aes_dec_iter.sv - directed and round-trip checks for aes_dec_iter
module tb_aes_dec_iter;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1407:0] g_input;
  logic [127:0]  e_input;
  logic          busy;
  logic          done;
  logic [127:0]  o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2047:0] sbox_tab;
  logic [1407:0] k_c1, k_b;

  always #5 clk = ~clk;

  aes_dec_iter #(.LATCH_KEYS(1), .NR(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .g_input (g_input),
    .e_input (e_input),
    .busy    (busy),
    .done    (done),
    .o       (o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sb(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return sbox_tab[idx -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] r;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 11; i++) r[128*i +: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
    return r;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] k);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ k[127:0];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int b = 0; b < 16; b++) s[127 - 8*b -: 8] = sb(s[127 - 8*b -: 8]);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      s = t;
      if (rd != 10) begin
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = s[127 - 32*c -: 32];
          s[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      end
      s = s ^ k[128*rd +: 128];
    end
    return s;
  endfunction

  // Starts one decryption in the current cycle and waits a bounded time for done.
  task automatic run_dec(input string tag, input logic [1407:0] k, input logic [127:0] ct,
                         input logic [127:0] exp);
    int lat;
    g_input = k;
    e_input = ct;
    start   = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'd11);
    check({tag, "_o"}, o, exp);
  endtask

  initial begin
    int dones;
    int spurious;
    logic [127:0]  rkey, rpt;
    logic [1407:0] rks;

    sbox_tab = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    k_c1 = expand_key(KEY_C1);
    k_b  = expand_key(KEY_B);

    rst     = 1'b0;
    start   = 1'b0;
    g_input = '0;
    e_input = '0;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_o", o, 0);
    rst = 1'b1;
    tick();

    // C.1 with cycle-exact busy/done profile
    g_input = k_c1;
    e_input = CT_C1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("c1_busy_%0d", c), busy, 128'(c <= 10));
      check($sformatf("c1_done_%0d", c), done, 128'(c == 11));
      if (c == 11) check("c1_o", o, PT_C1);
      if (c == 12) check("c1_o_hold", o, PT_C1);
      if (c < 12) tick();
    end

    run_dec("appb", k_b, CT_B, PT_B);

    // Keys and ciphertext trashed right after the accepting edge
    g_input = k_c1;
    e_input = CT_C1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    g_input = '1;
    e_input = '1;
    repeat (10) tick();
    check("latch_done", done, 1);
    check("latch_o", o, PT_C1);
    tick();

    // Back-to-back with an ignored start in cycle 5
    dones   = 0;
    g_input = k_c1;
    e_input = CT_C1;
    start   = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      start = 1'b0;
      if (done) dones++;
      if (c == 5) begin
        g_input = k_b;
        e_input = CT_B;
        start   = 1'b1;
      end
      if (c == 11) begin
        check("b2b_done11", done, 1);
        check("b2b_o11", o, PT_C1);
        start = 1'b1;
      end
      if (c == 12) check("b2b_busy12", busy, 1);
      if (c == 22) begin
        check("b2b_done22", done, 1);
        check("b2b_o22", o, PT_B);
      end
    end
    check("b2b_done_count", 128'(dones), 128'd2);
    tick();

    // Reset in the middle of an operation, then a fresh start
    spurious = 0;
    g_input  = k_c1;
    e_input  = CT_C1;
    start    = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      tick();
      start = 1'b0;
      if (c == 6) rst = 1'b0;
      if (c == 7) begin
        rst = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_o", o, 0);
      end
      if (c >= 7 && c <= 18 && done) spurious++;
      if (c == 8) begin
        g_input = k_c1;
        e_input = CT_C1;
        start   = 1'b1;
      end
      if (c == 19) begin
        check("rst_restart_done", done, 1);
        check("rst_restart_o", o, PT_C1);
      end
    end
    check("rst_no_done", 128'(spurious), 128'd0);

    // Random encrypt/decrypt round trips
    for (int i = 0; i < 100; i++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      rks  = expand_key(rkey);
      run_dec($sformatf("rt%0d", i), rks, encrypt(rpt, rks), rpt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
